pwm_timer: RTL and testbench

- Single-clock PWM block made of two parts: a programmable tick prescaler that emits a one-cycle step strobe every `ticks` clocks, and an N-bit PWM counter/comparator that advances once per step.
- Output high time is duty/2^N of each PWM period; PWM period is 2^N steps.
- Drives LEDs and motors from a slow, software-set duty value. Instantiated at the board clock, 12 MHz typical.

---
 rtl/pwm_timer.sv | 123 ++++++++++++
 tb/tb_pwm_timer.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_timer.sv
// pwm_timer: tick prescaler plus N-bit PWM counter/comparator.
// The prescaler emits a one-cycle step strobe every `ticks` clocks. The PWM
// counter advances once per strobe. `out` is high while pwm_cnt < duty.
// Optional build macro: PWM_TIMER_DUTY_SHADOW_EN. When it is defined, duty
// is latched at reset release and at each period wrap, so a period never
// changes shape part-way through.
module pwm_timer #(
   parameter int TICK_W = 7,
   parameter int N      = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ena,
   input  logic [TICK_W-1:0] ticks,
   input  logic [N-1:0]      duty,
   output logic              step,
   output logic              out
);

   localparam logic [TICK_W-1:0] TICK_ZERO = TICK_W'(0);
   localparam logic [TICK_W-1:0] TICK_ONE  = TICK_W'(1);
   localparam logic [N-1:0]      PWM_ZERO  = N'(0);
   localparam logic [N-1:0]      PWM_ONE   = N'(1);
   localparam logic [N-1:0]      PWM_MAX   = {N{1'b1}};

   logic [TICK_W-1:0] tick_cnt_r;
   logic [N-1:0]      pwm_cnt_r;
   logic              step_r;
   logic              out_r;

   logic              tick_zero_s;
   logic              tick_last_s;
   logic              pwm_adv_s;
   logic              pwm_wrap_s;
   logic [N-1:0]      duty_cmp_s;

   // Prescaler terminal-count and PWM advance/wrap decode.
   always_comb begin
      tick_zero_s = (ticks == TICK_ZERO);
      if (tick_zero_s) begin
         tick_last_s = 1'b0;
      end else begin
         // >= so that lowering ticks below the current count wraps at once.
         tick_last_s = (tick_cnt_r >= (ticks - TICK_ONE));
      end
      pwm_adv_s  = ena && step_r;
      pwm_wrap_s = pwm_adv_s && (pwm_cnt_r == PWM_MAX);
   end

   // Tick prescaler: counts clocks and raises step for one cycle per period.
   always_ff @(posedge clk) begin
      if (rst) begin
         tick_cnt_r <= TICK_ZERO;
         step_r     <= 1'b0;
      end else if (!ena) begin
         tick_cnt_r <= tick_cnt_r;
         step_r     <= 1'b0;
      end else if (tick_zero_s) begin
         tick_cnt_r <= TICK_ZERO;
         step_r     <= 1'b0;
      end else if (tick_last_s) begin
         tick_cnt_r <= TICK_ZERO;
         step_r     <= 1'b1;
      end else begin
         tick_cnt_r <= tick_cnt_r + TICK_ONE;
         step_r     <= 1'b0;
      end
   end

   // PWM counter: advances on the registered strobe, wraps naturally at 2^N.
   always_ff @(posedge clk) begin
      if (rst) begin
         pwm_cnt_r <= PWM_ZERO;
      end else if (pwm_adv_s) begin
         pwm_cnt_r <= pwm_cnt_r + PWM_ONE;
      end else begin
         pwm_cnt_r <= pwm_cnt_r;
      end
   end

`ifdef PWM_TIMER_DUTY_SHADOW_EN
   logic         rst_q_r;
   logic [N-1:0] duty_shadow_r;

   // Duty shadow: reloads on the first clock after reset and on period wrap.
   always_ff @(posedge clk) begin
      if (rst) begin
         rst_q_r       <= 1'b1;
         duty_shadow_r <= PWM_ZERO;
      end else begin
         rst_q_r <= 1'b0;
         if (rst_q_r || pwm_wrap_s) begin
            duty_shadow_r <= duty;
         end else begin
            duty_shadow_r <= duty_shadow_r;
         end
      end
   end

   // Compare source: the per-period shadow copy of duty.
   always_comb begin
      duty_cmp_s = duty_shadow_r;
   end
`else
   // Compare source: live duty, so a change shows up on the next clock.
   always_comb begin
      duty_cmp_s = duty;
   end
`endif

   // Registered PWM output; unsigned compare against the current count.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_r <= 1'b0;
      end else begin
         out_r <= ena && (pwm_cnt_r < duty_cmp_s);
      end
   end

   assign step = step_r;
   assign out  = out_r;

endmodule

// File: tb/tb_pwm_timer.sv
// Directed, table-driven bench for pwm_timer (TICK_W=7, N=4).
module tb_pwm_timer;

   localparam int TICK_W = 7;
   localparam int N      = 4;
   localparam int NVEC   = 19;

   logic              clk = 1'b0;
   logic              rst;
   logic              ena;
   logic [TICK_W-1:0] ticks;
   logic [N-1:0]      duty;
   logic              step;
   logic              out;

   int total = 0;
   int bad   = 0;

   typedef struct {
      int t;
      int d;
      int periods;
      int exp_high;
      int exp_steps;
   } vec_t;

   vec_t vecs [NVEC];

   always #5 clk = ~clk;

   pwm_timer #(.TICK_W(TICK_W), .N(N)) dut (
      .clk   (clk),
      .rst   (rst),
      .ena   (ena),
      .ticks (ticks),
      .duty  (duty),
      .step  (step),
      .out   (out)
   );

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d, want %0d", name, act, exp);
      end
   endtask

   // One rising edge, then return at the following falling edge.
   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   // Wait (bounded) until a step pulse is sampled.
   task automatic wait_step(input int limit, output int found);
      found = 0;
      for (int c = 0; c < limit; c++) begin
         tick();
         if (step) begin
            found = 1;
            break;
         end
      end
   endtask

   initial begin
      #5ms;
      $display("FAIL watchdog: got timeout, want finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int first, second, nsteps, found, hi, st, viol, exp_v;

      // Vector table: {ticks, duty, periods, expected high clocks, expected steps}
      vecs[0] = '{120, 0, 2, 0, 32};
      for (int d = 0; d < 16; d++) begin
         vecs[1 + d] = '{120, d, 1, d * 120, 16};
      end
      vecs[17] = '{1, 5, 1, 5, 16};
      vecs[18] = '{3, 7, 1, 21, 16};

      @(negedge clk);
      rst   = 1'b1;
      ena   = 1'b1;
      ticks = 7'd120;
      duty  = 4'd8;

      // Reset state
      tick();
      check("rst_step", int'(step), 0);
      check("rst_out", int'(out), 0);
      rst = 1'b0;

      // First strobe after 120 clocks, then every 120, one cycle wide
      first  = -1;
      second = -1;
      nsteps = 0;
      for (int c = 1; c <= 260; c++) begin
         tick();
         if (step) begin
            nsteps++;
            if (first < 0) first = c;
            else if (second < 0) second = c;
         end
      end
      check("first_step_cycle", first, 120);
      check("second_step_cycle", second, 240);
      check("step_pulse_count", nsteps, 2);

      // Lowering ticks below the current count wraps on the next clock
      ticks = 7'd120;
      do_reset();
      for (int c = 0; c < 50; c++) tick();
      check("pre_lower_step", int'(step), 0);
      ticks = 7'd10;
      tick();
      check("lower_wrap_step", int'(step), 1);
      nsteps = 0;
      for (int c = 0; c < 9; c++) begin
         tick();
         nsteps += int'(step);
      end
      check("lower_gap_steps", nsteps, 0);
      tick();
      check("lower_next_step", int'(step), 1);

      // Table: steady-state high time and step count over whole periods
      for (int i = 0; i < NVEC; i++) begin
         ena   = 1'b1;
         ticks = TICK_W'(vecs[i].t);
         duty  = N'(vecs[i].d);
         do_reset();
         wait_step(2 * vecs[i].t + 4, found);
         check($sformatf("vec%0d_step_seen", i), found, 1);
         hi = 0;
         st = 0;
         for (int c = 0; c < vecs[i].periods * 16 * vecs[i].t; c++) begin
            tick();
            hi += int'(out);
            st += int'(step);
         end
         check($sformatf("vec%0d_t%0d_d%0d_high", i, vecs[i].t, vecs[i].d), hi, vecs[i].exp_high);
         check($sformatf("vec%0d_steps", i), st, vecs[i].exp_steps);
      end

      // ena dropped mid-period for 120 clocks; period completes afterwards
      ena   = 1'b1;
      ticks = 7'd4;
      duty  = 4'd8;
      do_reset();
      wait_step(12, found);
      check("ena_step_seen", found, 1);
      hi   = 0;
      st   = 0;
      viol = 0;
      for (int c = 0; c < 64; c++) begin
         tick();
         hi += int'(out);
         st += int'(step);
         if (c == 21) begin
            ena = 1'b0;
            for (int j = 0; j < 120; j++) begin
               tick();
               if (step || out) viol++;
            end
            ena = 1'b1;
         end
      end
      check("ena_off_outputs_low", viol, 0);
      check("ena_resume_high", hi, 32);
      check("ena_resume_steps", st, 16);

      // ticks=0: no strobes, pwm_cnt stays 0 so out (duty=1) stays high
      ticks = 7'd0;
      duty  = 4'd1;
      do_reset();
      tick();
      hi = 0;
      st = 0;
      for (int c = 0; c < 100; c++) begin
         tick();
         hi += int'(out);
         st += int'(step);
      end
      check("ticks0_steps", st, 0);
      check("ticks0_high", hi, 100);

      // Duty change mid-period (live: next clock; shadow: after wrap)
      ticks = 7'd2;
      duty  = 4'd4;
      do_reset();
      wait_step(8, found);
      check("duty_chg_step_seen", found, 1);
      hi = 0;
      for (int c = 1; c <= 31; c++) begin
         tick();
         hi += int'(out);
         if (c == 10) duty = 4'd12;
      end
`ifdef PWM_TIMER_DUTY_SHADOW_EN
      exp_v = 7;
`else
      exp_v = 20;
`endif
      check("duty_chg_period", hi, exp_v);
      hi = 0;
      for (int c = 0; c < 32; c++) begin
         tick();
         hi += int'(out);
      end
      check("duty_chg_next_period", hi, 24);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
